// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL field positions, mode encodings and FSM states for multi_timer.
// Build option: MULTI_TIMER_PRESCALE_EN enables the CTRL[7:4] tick prescaler.
package multi_timer_pkg;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_PRESET = 4'h4;
   localparam logic [3:0] OFF_COUNT  = 4'h8;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;
   localparam int CTRL_PS_LO   = 4;
   localparam int CTRL_PS_HI   = 7;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

`ifdef MULTI_TIMER_PRESCALE_EN
   localparam logic [7:0] CTRL_WMASK = 8'hFF;
`else
   localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

   // Register index as seen on addr[3:2].
   function automatic logic [1:0] reg_index(input logic [3:0] off);
      return off[3:2];
   endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// timer_channel: one timer with CTRL/PRESET/COUNT registers and IDLE/LOAD/CNT/INT FSM.
// Build option: MULTI_TIMER_PRESCALE_EN adds a 15-bit per-channel tick prescaler.
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  reg_sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0]       SEL_CTRL   = reg_index(OFF_CTRL);
   localparam logic [1:0]       SEL_PRESET = reg_index(OFF_PRESET);
   localparam logic [1:0]       SEL_COUNT  = reg_index(OFF_COUNT);
   localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [7:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] preset_q, preset_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic             irq_q, irq_d;
   logic             wr_ctrl, wr_preset, auto_mode, tick;
   logic [31:0]      preset_ext, count_ext;
   logic             unused_wdata;

   assign unused_wdata = ^wdata;

`ifdef MULTI_TIMER_PRESCALE_EN
   logic [14:0] ps_cnt_q, ps_cnt_d, ps_mask;

   // Prescale counter runs only while counting; a tick fires when its low PS bits are all ones.
   always_comb begin
      ps_mask = (15'd1 << ctrl_q[CTRL_PS_HI:CTRL_PS_LO]) - 15'd1;
      tick    = (ps_cnt_q & ps_mask) == ps_mask;
      if (state_q == ST_LOAD) begin
         ps_cnt_d = 15'd0;
      end else if (state_q == ST_CNT) begin
         ps_cnt_d = ps_cnt_q + 15'd1;
      end else begin
         ps_cnt_d = ps_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ps_cnt_q <= 15'd0;
      else       ps_cnt_q <= ps_cnt_d;
   end
`else
   assign tick = 1'b1;
`endif

   // Register writes and FSM next state; a CTRL write at expiry wins over entering INT.
   always_comb begin
      wr_ctrl   = we && (reg_sel == SEL_CTRL);
      wr_preset = we && (reg_sel == SEL_PRESET);
      auto_mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
      ctrl_d    = wr_ctrl ? (wdata[7:0] & CTRL_WMASK) : ctrl_q;
      preset_d  = wr_preset ? wdata[WIDTH-1:0] : preset_q;
      count_d   = count_q;
      state_d   = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            else                 state_d = ST_IDLE;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = ST_IDLE;
            end else if (!tick) begin
               state_d = ST_CNT;
            end else if (count_q > ONE) begin
               count_d = count_q - ONE;
            end else begin
               count_d = {WIDTH{1'b0}};
               if (wr_ctrl) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_INT;
                  if (!auto_mode) ctrl_d[CTRL_EN] = 1'b0;
                  else            ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN];
               end
            end
         end
         ST_INT: begin
            if (auto_mode)    state_d = ST_LOAD;
            else if (wr_ctrl) state_d = ST_IDLE;
            else              state_d = ST_INT;
         end
         default: state_d = ST_IDLE;
      endcase
      irq_d = (state_d == ST_INT) && ctrl_d[CTRL_IM];
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= 8'd0;
         preset_q <= {WIDTH{1'b0}};
         count_q  <= {WIDTH{1'b0}};
         state_q  <= ST_IDLE;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         state_q  <= state_d;
         irq_q    <= irq_d;
      end
   end

   // Zero-extended read mux for this channel.
   always_comb begin
      preset_ext             = 32'd0;
      preset_ext[WIDTH-1:0]  = preset_q;
      count_ext              = 32'd0;
      count_ext[WIDTH-1:0]   = count_q;
      case (reg_sel)
         SEL_CTRL:   rdata = {24'd0, ctrl_q};
         SEL_PRESET: rdata = preset_ext;
         SEL_COUNT:  rdata = count_ext;
         default:    rdata = 32'd0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent timer_channel instances with address decode and read mux.
// Build option: MULTI_TIMER_PRESCALE_EN (see multi_timer_pkg).
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          addr,
   input  logic                we,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic [CHANNELS-1:0] irq
);

   logic [2:0]  ch_sel;
   logic [1:0]  reg_sel;
   logic [31:0] ch_rdata [CHANNELS];
   logic        unused_addr;

   assign ch_sel      = addr[6:4];
   assign reg_sel     = addr[3:2];
   assign unused_addr = ^addr[1:0];

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .we      (we && (ch_sel == 3'(i))),
            .reg_sel (reg_sel),
            .wdata   (wdata),
            .rdata   (ch_rdata[i]),
            .irq     (irq[i])
         );
      end
   endgenerate

   // Unpopulated channel slots fall through to zero.
   always_comb begin
      rdata = 32'd0;
      for (int i = 0; i < CHANNELS; i++) begin
         rdata = rdata | ((ch_sel == 3'(i)) ? ch_rdata[i] : 32'd0);
      end
   end

endmodule

// File: tb/tb_multi_timer.sv
// Directed and randomized checks of multi_timer against expiry-time arithmetic.
module tb_multi_timer;

   localparam logic [6:0] CTRL0   = 7'h00;
   localparam logic [6:0] PRESET0 = 7'h04;
   localparam logic [6:0] COUNT0  = 7'h08;
   localparam logic [6:0] CTRL1   = 7'h10;
   localparam logic [6:0] PRESET1 = 7'h14;
   localparam logic [6:0] COUNT1  = 7'h18;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [1:0]  irq;
   int          total = 0;
   int          bad = 0;

   multi_timer #(.CHANNELS(2), .WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      we    = 1'b0;
      step();
      reset = 1'b0;
   endtask

   // Cycles from the enabling write to irq: effective preset plus LOAD and the write itself.
   function automatic int period(input int p);
      return ((p < 1) ? 1 : p) + 2;
   endfunction

   function automatic logic exp_irq(input int k, input int p, input bit im, input bit autor);
      int l;
      l = period(p);
      if (k < l) return 1'b0;
      if (autor) return im && ((k % l) == 0);
      return im;
   endfunction

   function automatic logic [31:0] exp_count(input int k, input int p, input bit autor);
      int l;
      int m;
      l = period(p);
      if (!autor && k >= l) return 32'd0;
      m = autor ? (k % l) : k;
      if (m < 2) return 32'd0;
      return 32'(p - (m - 2));
   endfunction

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = 7'd0;
      wdata = 32'd0;
      step();
      step();
      reset = 1'b0;
      check("reset_irq", {30'd0, irq}, 32'd0);
      chk_rd("reset_ctrl0", CTRL0, 32'd0);
      chk_rd("reset_preset0", PRESET0, 32'd0);
      chk_rd("reset_count0", COUNT0, 32'd0);

      // One-shot, PRESET=5: irq at write+7, EN self-clears, CTRL write drops irq.
      wr(PRESET0, 32'd5);
      wr(CTRL0, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("oneshot_irq_k%0d", k), {30'd0, irq}, (k == 7) ? 32'd1 : 32'd0);
         if (k == 2) chk_rd("oneshot_count_k2", COUNT0, 32'd5);
      end
      chk_rd("oneshot_ctrl_en_clear", CTRL0, 32'h8);
      repeat (3) step();
      check("oneshot_irq_held", {30'd0, irq}, 32'd1);
      wr(CTRL0, 32'h0);
      check("oneshot_irq_drop", {30'd0, irq}, 32'd0);

      // Auto-reload on channel 1, PRESET=3: period 5.
      do_reset();
      wr(PRESET1, 32'd3);
      wr(CTRL1, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("reload_irq_k%0d", k), {30'd0, irq}, ((k % 5) == 0) ? 32'd2 : 32'd0);
      end
      chk_rd("reload_ctrl_en_kept", CTRL1, 32'hB);
      wr(CTRL1, 32'h0);
      repeat (4) step();
      check("reload_stopped", {30'd0, irq}, 32'd0);

      // PRESET=0 behaves as 1.
      do_reset();
      wr(CTRL0, 32'h9);
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("preset0_irq_k%0d", k), {30'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
      end

      // IM=0: no irq, EN still clears.
      do_reset();
      wr(PRESET0, 32'd2);
      wr(CTRL0, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("nomask_irq_k%0d", k), {30'd0, irq}, 32'd0);
      end
      chk_rd("nomask_ctrl", CTRL0, 32'h0);
      chk_rd("nomask_count", COUNT0, 32'd0);

      // CTRL write on the cycle that would enter INT suppresses irq.
      do_reset();
      wr(PRESET0, 32'd2);
      wr(CTRL0, 32'h9);
      repeat (3) step();
      wr(CTRL0, 32'h8);
      check("collide_irq", {30'd0, irq}, 32'd0);
      chk_rd("collide_ctrl", CTRL0, 32'h8);
      repeat (2) step();
      check("collide_irq_later", {30'd0, irq}, 32'd0);

      // Unused CTRL bits, offset 0xC and absent channel 7.
      do_reset();
      wr(CTRL0, 32'hFFFF_FFF6);
`ifdef MULTI_TIMER_PRESCALE_EN
      chk_rd("ctrl_unused_bits", CTRL0, 32'hF6);
`else
      chk_rd("ctrl_unused_bits", CTRL0, 32'h06);
`endif
      chk_rd("offset_c_zero", 7'h0C, 32'd0);
      wr(7'h70, 32'h9);
      wr(7'h74, 32'd7);
      chk_rd("ch7_ctrl_zero", 7'h70, 32'd0);
      chk_rd("ch7_preset_zero", 7'h74, 32'd0);
      chk_rd("ch7_no_alias_ch1", CTRL1, 32'd0);
      check("ch7_irq", {30'd0, irq}, 32'd0);

      // Simultaneous expiry on both channels.
      do_reset();
      wr(PRESET0, 32'd5);
      wr(PRESET1, 32'd4);
      wr(CTRL0, 32'h9);
      wr(CTRL1, 32'h9);
      for (int k = 2; k <= 7; k++) begin
         step();
         check($sformatf("simul_irq_k%0d", k), {30'd0, irq}, (k == 7) ? 32'd3 : 32'd0);
      end

      // PRESET written mid-count only takes effect at the next LOAD.
      do_reset();
      wr(PRESET0, 32'd10);
      wr(CTRL0, 32'h9);
      repeat (3) step();
      wr(PRESET0, 32'd3);
      chk_rd("midpreset_count", COUNT0, 32'd8);
      chk_rd("midpreset_preset", PRESET0, 32'd3);
      for (int k = 5; k <= 12; k++) begin
         step();
         check($sformatf("midpreset_irq_k%0d", k), {30'd0, irq}, (k == 12) ? 32'd1 : 32'd0);
      end
      wr(CTRL0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("newpreset_irq_k%0d", k), {30'd0, irq}, (k == 5) ? 32'd1 : 32'd0);
      end

      // Prescaler: PS=2, PRESET=4.
      do_reset();
      wr(PRESET0, 32'd4);
      wr(CTRL0, 32'h29);
`ifdef MULTI_TIMER_PRESCALE_EN
      for (int k = 1; k <= 18; k++) begin
         step();
         check($sformatf("ps_irq_k%0d", k), {30'd0, irq}, (k == 18) ? 32'd1 : 32'd0);
      end
      chk_rd("ps_ctrl_after", CTRL0, 32'h28);
`else
      chk_rd("ps_ctrl_ignored", CTRL0, 32'h9);
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("ps_irq_k%0d", k), {30'd0, irq}, (k == 6) ? 32'd1 : 32'd0);
      end
`endif

      // Reset in the middle of counting.
      do_reset();
      wr(PRESET0, 32'd100);
      wr(CTRL0, 32'h9);
      repeat (20) step();
      chk_rd("midreset_count_before", COUNT0, 32'd82);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_irq", {30'd0, irq}, 32'd0);
      chk_rd("midreset_count", COUNT0, 32'd0);
      chk_rd("midreset_ctrl", CTRL0, 32'd0);
      step();
      chk_rd("midreset_preset", PRESET0, 32'd0);
      check("midreset_irq_later", {30'd0, irq}, 32'd0);

      // Randomized trials: both channels with random preset/mode/mask, channel 1 enabled one cycle later.
      for (int t = 0; t < 20; t++) begin
         int p0;
         int p1;
         bit [1:0] m0;
         bit [1:0] m1;
         bit im0;
         bit im1;
         p0  = int'($urandom_range(0, 12));
         p1  = int'($urandom_range(0, 12));
         m0  = 2'($urandom_range(0, 3));
         m1  = 2'($urandom_range(0, 3));
         im0 = 1'($urandom_range(0, 1));
         im1 = 1'($urandom_range(0, 1));
         do_reset();
         wr(PRESET0, 32'(p0));
         wr(PRESET1, 32'(p1));
         wr(CTRL0, {28'd0, im0, m0, 1'b1});
         for (int k = 1; k <= 40; k++) begin
            if (k == 1) wr(CTRL1, {28'd0, im1, m1, 1'b1});
            else        step();
            check($sformatf("rand%0d_irq_k%0d", t, k), {30'd0, irq},
                  {30'd0, exp_irq(k - 1, p1, im1, m1 == 2'd1), exp_irq(k, p0, im0, m0 == 2'd1)});
            chk_rd($sformatf("rand%0d_count0_k%0d", t, k), COUNT0, exp_count(k, p0, m0 == 2'd1));
            chk_rd($sformatf("rand%0d_count1_k%0d", t, k), COUNT1, exp_count(k - 1, p1, m1 == 2'd1));
         end
         chk_rd($sformatf("rand%0d_ctrl0", t), CTRL0, {28'd0, im0, m0, m0 == 2'd1});
         chk_rd($sformatf("rand%0d_ctrl1", t), CTRL1, {28'd0, im1, m1, m1 == 2'd1});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent timer channels, legal range 1..8.
REQ-002 Parameter WIDTH, default 32: counter and preset width, legal range 8..32.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 addr  input  7  word-aligned byte address; channel = addr[6:4], register = addr[3:2].
REQ-006 we  input  1  write strobe, qualified by addr, effective on the rising clk edge.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  combinational read data for addr.
REQ-009 irq  output  CHANNELS  per-channel interrupt request, bit n belongs to channel n; feeds the CPU hardware-interrupt vector.

Function
REQ-010 Each channel SHALL have three registers: CTRL (offset 0x0), PRESET (0x4) and COUNT (0x8, read-only); offset 0xC and channels >= CHANNELS SHALL read 0 and ignore writes.
REQ-011 CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x reserved and treated as one-shot), [3] IM (interrupt mask, 1 = enabled); unused bits SHALL read 0.
REQ-012 PRESET and COUNT SHALL be WIDTH bits wide and zero-extended on read; upper wdata bits are discarded on write.
REQ-013 Per-channel FSM states IDLE, LOAD, CNT, INT; after reset every channel SHALL be in IDLE.
REQ-014 IDLE -> LOAD when EN=1.
REQ-015 LOAD: COUNT <= PRESET, then -> CNT on the next cycle.
REQ-016 CNT with EN=0 -> IDLE and COUNT holds; CNT with COUNT>1 decrements COUNT by 1 per tick; CNT with COUNT<=1 sets COUNT <= 0 and moves to INT. PRESET=0 therefore behaves as PRESET=1.
REQ-017 INT, one-shot mode: the hardware SHALL clear EN and hold irq[n] = IM until the next CTRL write to that channel, then -> IDLE.
REQ-018 INT, auto-reload mode: irq[n] = IM for exactly one cycle, then -> LOAD; EN stays set.
REQ-019 Latency from the CTRL write setting EN (PRESET = P >= 1) to irq assertion SHALL be P+2 cycles when no prescaler is active.
REQ-020 A CTRL write in the same cycle as entry to INT SHALL take priority: the new CTRL value is applied and irq stays deasserted.
REQ-021 A PRESET write during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-022 Channels SHALL operate independently; simultaneous expiry SHALL assert several irq bits in the same cycle.

Reset
REQ-023 On reset, all CTRL, PRESET and COUNT registers SHALL be 0, all FSMs SHALL be in IDLE and irq SHALL be 0, including when reset arrives in the middle of counting.

Configuration
REQ-024 Macro MULTI_TIMER_PRESCALE_EN defined: CTRL[7:4] = PS; a tick occurs once every 2^PS clk cycles, driven by a per-channel 15-bit prescale counter that is cleared in LOAD; latency becomes 2 + P*2^PS cycles.
REQ-025 Macro MULTI_TIMER_PRESCALE_EN undefined: CTRL[7:4] SHALL read 0, writes to those bits are ignored, a tick occurs every cycle, and no prescale logic is generated.

Structure
REQ-026 A shared package SHALL hold: register offsets (CTRL/PRESET/COUNT), CTRL bit positions, the MODE encodings and the FSM state enumeration.
REQ-027 Sub-module timer_channel SHALL implement one channel (registers, FSM, optional prescaler); multi_timer SHALL instantiate CHANNELS copies through a generate loop and provide the address decode and read mux.

Verification
REQ-028 Reset mid-count: PRESET0=100, EN=1, reset at cycle 20 -> COUNT0=0, CTRL0=0, irq=0 on the next cycle.
REQ-029 One-shot: PRESET0=5, CTRL0=0x9 -> irq[0] rises 7 cycles after the write and stays high, CTRL0 reads 0x8; a CTRL0 write of 0 drops irq[0] on the next cycle.
REQ-030 Auto-reload: PRESET1=3, CTRL1=0xB -> irq[1] pulses one cycle wide at a period of 5 cycles (INT, LOAD, then three CNT cycles) for 4 periods.
REQ-031 Boundaries: PRESET=0 behaves as 1; IM=0 gives no irq while EN still clears in one-shot mode; a CTRL write coinciding with INT gives no irq; channel 7 with CHANNELS=2 reads 0.
REQ-032 Prescale (macro defined): PRESET0=4, CTRL0 = 0x9 | (2<<4) -> irq[0] asserts 18 cycles after the write; with the macro undefined, CTRL0 reads 0x9.
